// File: rtl/mul_opnd_fifo_pkg.sv
// Shared multpool definitions: default bus offsets, status/control bit map.
package mul_opnd_fifo_pkg;

  localparam logic [15:0] MP_CFG_ADDR = 16'h0000;
  localparam logic [15:0] MP_STS_ADDR = 16'h0004;

  // Status word bit positions
  localparam int unsigned STS_EMPTY_BIT = 0;
  localparam int unsigned STS_FULL_BIT  = 1;
  localparam int unsigned STS_OVF_BIT   = 2;
  localparam int unsigned STS_CNT_LSB   = 3;
  localparam int unsigned STS_CNT_W     = 7;

  // Control write bit positions
  localparam int unsigned CTL_FLUSH_BIT   = 0;
  localparam int unsigned CTL_CLR_OVF_BIT = 1;

  // Assemble the 32-bit status word; unused bits read as zero.
  function automatic logic [31:0] sts_pack(input logic [STS_CNT_W-1:0] cnt,
                                           input logic ovf,
                                           input logic full,
                                           input logic empty);
    logic [31:0] w;
    w = '0;
    w[STS_EMPTY_BIT]               = empty;
    w[STS_FULL_BIT]                = full;
    w[STS_OVF_BIT]                 = ovf;
    w[STS_CNT_LSB +: STS_CNT_W]    = cnt;
    return w;
  endfunction

endpackage

// File: rtl/mul_fifo_ram.sv
// Operand storage: synchronous write, asynchronous read, no reset.
module mul_fifo_ram #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 256
) (
  input  logic                     i_clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [WIDTH-1:0]         o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Write port
  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mul_opnd_fifo.sv
// Operand-pair FIFO between the bus and the multpool, first-word fall-through.
module mul_opnd_fifo
  import mul_opnd_fifo_pkg::*;
#(
  parameter logic [15:0] CFG_ADDR = MP_CFG_ADDR,
  parameter logic [15:0] STS_ADDR = MP_STS_ADDR,
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned DWIDTH   = 128
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic                  wr_en,
  input  logic [31:0]           wr_addr,
  input  logic [2*DWIDTH-1:0]   wdata,
  input  logic                  rd_en,
  input  logic [31:0]           rd_addr,
  output logic [31:0]           rdata,
  output logic                  rd_en_out,
  output logic                  opnd_valid,
  input  logic                  opnd_ready,
  output logic [DWIDTH-1:0]     opnd_a,
  output logic [DWIDTH-1:0]     opnd_b,
  output logic                  fifo_full,
  output logic                  fifo_empty,
  output logic                  ovf_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]          r_wr_ptr;
  logic [AW:0]          r_rd_ptr;
  logic                 r_ovf;
  logic [31:0]          r_rdata;

  logic                 w_push;
  logic                 w_pop;
  logic                 w_sts_wr;
  logic                 w_flush;
  logic                 w_clr_ovf;
  logic                 w_push_ok;
  logic                 w_drop;
  logic                 w_full;
  logic                 w_empty;
  logic [AW:0]          w_count;
  logic [2*DWIDTH-1:0]  w_head;
  logic                 w_unused;

  assign w_push    = wr_en && (wr_addr[15:0] == CFG_ADDR);
  assign w_sts_wr  = wr_en && (wr_addr[15:0] == STS_ADDR);
  assign w_flush   = w_sts_wr && wdata[CTL_FLUSH_BIT];
  assign w_clr_ovf = w_sts_wr && wdata[CTL_CLR_OVF_BIT];

  assign w_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_count   = r_wr_ptr - r_rd_ptr;

  assign w_pop     = !w_empty && opnd_ready;
  // A full FIFO still takes a push when the head leaves in the same cycle.
  assign w_push_ok = w_push && (!w_full || w_pop);
  assign w_drop    = w_push && w_full && !w_pop;

  assign w_unused  = ^{wr_addr[31:16], rd_addr[31:16]};

  mul_fifo_ram #(
    .DEPTH (DEPTH),
    .WIDTH (2*DWIDTH)
  ) u_ram (
    .i_clk   (hclk),
    .i_we    (w_push_ok),
    .i_waddr (r_wr_ptr[AW-1:0]),
    .i_wdata (wdata),
    .i_raddr (r_rd_ptr[AW-1:0]),
    .o_rdata (w_head)
  );

  // Pointer update; flush wins over a same-cycle pop
  always_ff @(posedge hclk) begin
    if (hreset || w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop)     r_rd_ptr <= r_rd_ptr + PTR_ONE;
    end
  end

  // Sticky overflow flag, set-dominant over clear
  always_ff @(posedge hclk) begin
    if (hreset)         r_ovf <= 1'b0;
    else if (w_drop)    r_ovf <= 1'b1;
    else if (w_clr_ovf) r_ovf <= 1'b0;
  end

  // Registered status read data, zero when not addressed
  always_ff @(posedge hclk) begin
    if (hreset)         r_rdata <= '0;
    else if (rd_en_out) r_rdata <= sts_pack(STS_CNT_W'(w_count), r_ovf, w_full, w_empty);
    else                r_rdata <= '0;
  end

  assign rd_en_out  = rd_en && (rd_addr[15:0] == STS_ADDR);
  assign rdata      = r_rdata;
  assign opnd_valid = !w_empty;
  assign opnd_a     = opnd_valid ? w_head[DWIDTH-1:0]        : '0;
  assign opnd_b     = opnd_valid ? w_head[2*DWIDTH-1:DWIDTH] : '0;
  assign fifo_full  = w_full;
  assign fifo_empty = w_empty;
  assign ovf_err    = r_ovf;

endmodule

// File: tb/tb_mul_opnd_fifo.sv
// Scoreboard bench for mul_opnd_fifo with a queue-based reference model.
module tb_mul_opnd_fifo;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned DW    = 128;
  localparam logic [15:0] CFG   = 16'h0000;
  localparam logic [15:0] STS   = 16'h0004;

  logic            hclk = 1'b0;
  logic            hreset = 1'b1;
  logic            wr_en = 1'b0;
  logic [31:0]     wr_addr = '0;
  logic [2*DW-1:0] wdata = '0;
  logic            rd_en = 1'b0;
  logic [31:0]     rd_addr = '0;
  logic            opnd_ready = 1'b0;
  logic [31:0]     rdata;
  logic            rd_en_out;
  logic            opnd_valid;
  logic [DW-1:0]   opnd_a;
  logic [DW-1:0]   opnd_b;
  logic            fifo_full;
  logic            fifo_empty;
  logic            ovf_err;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [2*DW-1:0] sb_q[$];
  int              m_cnt = 0;
  logic            m_ovf = 1'b0;
  logic [31:0]     m_rdata = '0;
  int              n_pushed = 0;
  int              n_popped = 0;

  mul_opnd_fifo #(
    .CFG_ADDR (CFG),
    .STS_ADDR (STS),
    .DEPTH    (DEPTH),
    .DWIDTH   (DW)
  ) dut (
    .hclk       (hclk),
    .hreset     (hreset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wdata      (wdata),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rdata      (rdata),
    .rd_en_out  (rd_en_out),
    .opnd_valid (opnd_valid),
    .opnd_ready (opnd_ready),
    .opnd_a     (opnd_a),
    .opnd_b     (opnd_b),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .ovf_err    (ovf_err)
  );

  always #5 hclk = ~hclk;

  task automatic check(input string name, input logic [2*DW-1:0] act, input logic [2*DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [2*DW-1:0] rand_word();
    logic [2*DW-1:0] w;
    for (int unsigned i = 0; i < 2*DW/32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // Reference model: FIFO occupancy and contents per clock edge
  always @(posedge hclk) begin
    logic pop_m, push_m, sts_m, acc_m, drop_m;
    if (hreset) begin
      m_cnt   = 0;
      m_ovf   = 1'b0;
      m_rdata = '0;
      sb_q.delete();
    end else begin
      pop_m  = (m_cnt > 0) && opnd_ready;
      push_m = wr_en && (wr_addr[15:0] == CFG);
      sts_m  = wr_en && (wr_addr[15:0] == STS);
      acc_m  = push_m && ((m_cnt < DEPTH) || pop_m);
      drop_m = push_m && !acc_m;
      if (rd_en && (rd_addr[15:0] == STS))
        m_rdata = {22'b0, 7'(m_cnt), m_ovf, (m_cnt == DEPTH), (m_cnt == 0)};
      else
        m_rdata = '0;
      if (sts_m && wdata[0]) begin
        m_cnt = 0;
        sb_q.delete();
      end else begin
        if (pop_m) m_cnt--;
        if (acc_m) begin
          sb_q.push_back(wdata);
          m_cnt++;
          n_pushed++;
        end
      end
      if (sts_m && wdata[1]) m_ovf = 1'b0;
      if (drop_m) m_ovf = 1'b1;
    end
  end

  // Monitor: compare flags every cycle, pop scoreboard on each handshake
  always @(negedge hclk) begin
    check("empty", fifo_empty, m_cnt == 0);
    check("full", fifo_full, m_cnt == DEPTH);
    check("valid", opnd_valid, m_cnt != 0);
    check("ovf_err", ovf_err, m_ovf);
    check("rdata", rdata, m_rdata);
    check("rd_en_out", rd_en_out, rd_en && (rd_addr[15:0] == STS));
    if (opnd_valid) begin
      if (sb_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL head_underflow: got valid head %h expected no entry", {opnd_b, opnd_a});
      end else begin
        check("head", {opnd_b, opnd_a}, sb_q[0]);
        if (opnd_ready) begin
          void'(sb_q.pop_front());
          n_popped++;
        end
      end
    end else begin
      check("idle_zero", {opnd_b, opnd_a}, '0);
    end
  end

  task automatic cycle();
    @(posedge hclk);
    #1;
  endtask

  task automatic push(input logic [2*DW-1:0] d);
    wr_en   = 1'b1;
    wr_addr = {16'($urandom), CFG};
    wdata   = d;
    cycle();
    wr_en   = 1'b0;
  endtask

  task automatic sts_write(input logic [1:0] ctl);
    logic [2*DW-1:0] d;
    d       = rand_word();
    d[1:0]  = ctl;
    wr_en   = 1'b1;
    wr_addr = {16'($urandom), STS};
    wdata   = d;
    cycle();
    wr_en   = 1'b0;
  endtask

  task automatic sts_read();
    rd_en   = 1'b1;
    rd_addr = {16'($urandom), STS};
    cycle();
    rd_en   = 1'b0;
  endtask

  initial begin
    int unsigned r;
    repeat (2) cycle();
    hreset = 1'b0;
    cycle();

    // Single pair, held while not ready
    opnd_ready = 1'b0;
    push({128'd2, 128'd1});
    check("req027_valid", opnd_valid, 1'b1);
    check("req027_a", opnd_a, 128'd1);
    check("req027_b", opnd_b, 128'd2);
    repeat (3) cycle();
    check("req027_hold_a", opnd_a, 128'd1);
    check("req027_hold_b", opnd_b, 128'd2);
    opnd_ready = 1'b1;
    cycle();
    opnd_ready = 1'b0;
    cycle();

    // Fill to full, status read, overflow drop
    for (int unsigned i = 0; i < DEPTH; i++) push(rand_word());
    check("req028_full", fifo_full, 1'b1);
    sts_read();
    check("req028_sts", rdata, 32'h82);
    push(rand_word());
    check("req028_ovf", ovf_err, 1'b1);
    cycle();

    // Full with simultaneous push and pop
    sts_write(2'b10);
    opnd_ready = 1'b1;
    push(rand_word());
    opnd_ready = 1'b0;
    check("req029_full", fifo_full, 1'b1);
    check("req029_ovf", ovf_err, 1'b0);
    sts_read();
    check("req029_sts", rdata, 32'h82);

    // Drain
    opnd_ready = 1'b1;
    repeat (DEPTH + 4) cycle();
    opnd_ready = 1'b0;

    // Random interleaving across pointer wrap
    for (int unsigned i = 0; i < 160; i++) begin
      opnd_ready = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 19);
      if (r < 10) begin
        push(rand_word());
      end else if (r < 13) begin
        sts_read();
      end else if (r == 13) begin
        sts_write(2'b10);
      end else if (r == 14) begin
        wr_en   = 1'b1;
        wr_addr = {16'($urandom), 16'h0008};
        wdata   = rand_word();
        cycle();
        wr_en   = 1'b0;
      end else begin
        cycle();
      end
    end
    opnd_ready = 1'b1;
    repeat (DEPTH + 4) cycle();
    opnd_ready = 1'b0;
    check("req030_drained", fifo_empty, 1'b1);
    n_vec++;
    if (n_popped < 40 + DEPTH) begin
      n_err++;
      $display("FAIL req030_volume: got %0d pops expected at least %0d", n_popped, 40 + DEPTH);
    end

    // Flush and clear-overflow with entries present
    for (int unsigned i = 0; i <= DEPTH; i++) push(rand_word());
    check("req031_ovf_set", ovf_err, 1'b1);
    sts_write(2'b01);
    for (int unsigned i = 0; i < 5; i++) push(rand_word());
    check("req031_ovf_kept", ovf_err, 1'b1);
    sts_write(2'b11);
    check("req031_empty", fifo_empty, 1'b1);
    check("req031_ovf_clr", ovf_err, 1'b0);
    sts_read();
    check("req031_sts", rdata, 32'h1);

    // Reset mid-operation
    for (int unsigned i = 0; i < 7; i++) push(rand_word());
    rd_en   = 1'b1;
    rd_addr = {16'h0000, STS};
    hreset  = 1'b1;
    cycle();
    hreset  = 1'b0;
    rd_en   = 1'b0;
    check("req032_valid", opnd_valid, 1'b0);
    check("req032_rdata", rdata, 32'h0);
    check("req032_empty", fifo_empty, 1'b1);
    opnd_ready = 1'b1;
    repeat (3) cycle();
    opnd_ready = 1'b0;
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mul_opnd_fifo.md
MUL_OPND_FIFO -- requirements
Module: mul_opnd_fifo

Interface
REQ-001 SHALL have parameter CFG_ADDR, default 16'h0, meaning the bus push address for operand pairs.
REQ-002 SHALL have parameter STS_ADDR, default 16'h4, meaning the status/control register address.
REQ-003 SHALL have parameter DEPTH, default 16, meaning the entry count; it is a power of two, at least 2.
REQ-004 SHALL have parameter DWIDTH, default 128, meaning the width of one operand.
REQ-005 SHALL have the following ports (name, direction, width, meaning):
- hclk, in, 1: sole clock, rising edge.
- hreset, in, 1: synchronous, active-high reset.
- wr_en, in, 1: bus write strobe.
- wr_addr, in, 32: bus write address; bits [15:0] are decoded.
- wdata, in, 2*DWIDTH: write data; {opnd_b, opnd_a} on push, control bits on STS_ADDR.
- rd_en, in, 1: bus read strobe.
- rd_addr, in, 32: bus read address; bits [15:0] are decoded.
- rdata, out, 32: registered status read data.
- rd_en_out, out, 1: rd_en AND (rd_addr[15:0]==STS_ADDR), combinational.
- opnd_valid, out, 1: head entry available to multpool.
- opnd_ready, in, 1: multpool accepts the head entry.
- opnd_a, out, DWIDTH: head entry, low half.
- opnd_b, out, DWIDTH: head entry, high half.
- fifo_full, out, 1: all entries occupied.
- fifo_empty, out, 1: no entries occupied.
- ovf_err, out, 1: sticky flag, a push was dropped.

Function
REQ-006 SHALL define push = wr_en AND wr_addr[15:0]==CFG_ADDR; pop = opnd_valid AND opnd_ready.
REQ-007 SHALL use wr_ptr/rd_ptr of width log2(DEPTH)+1; the MSB is the wrap bit, low bits index storage.
REQ-008 SHALL assert fifo_empty when the pointers are fully equal, and fifo_full when the MSBs differ and the low bits are equal; both are combinational from the pointers.
REQ-009 SHALL write wdata to mem[wr_ptr] and increment wr_ptr on an accepted push.
REQ-010 SHALL accept a push when ~fifo_full, or when fifo_full AND pop occurs in the same cycle.
REQ-011 SHALL drop a push when fifo_full with no pop: no storage or pointer change, and ovf_err set at the next edge.
REQ-012 SHALL drive opnd_valid = ~fifo_empty, with opnd_a/opnd_b = mem[rd_ptr] combinationally (first-word fall-through).
REQ-013 SHALL drive opnd_a/opnd_b to 0 when opnd_valid is 0.
REQ-014 SHALL increment rd_ptr on pop; there is no empty bypass, so a push into an empty FIFO at edge N gives opnd_valid=1 after edge N.
REQ-015 SHALL hold opnd_a/opnd_b stable while opnd_valid=1 and opnd_ready=0.
REQ-016 SHALL let simultaneous push and pop (non-full) change both pointers, leaving occupancy unchanged.
REQ-017 SHALL interpret a write to STS_ADDR as: wdata[0]=1 flushes (both pointers to 0); wdata[1]=1 clears ovf_err.
REQ-018 SHALL give flush priority over a same-cycle pop; a push cannot coincide with a flush, since the addresses differ.
REQ-019 SHALL, one cycle after rd_en_out, set rdata = {22'b0, count[log2(DEPTH):0] zero-extended to 7 bits, ovf_err, fifo_full, fifo_empty}; count = wr_ptr - rd_ptr.
REQ-020 SHALL set rdata to 0 in any cycle after which rd_en_out was 0.
REQ-021 SHALL make ovf_err set-dominant if a set and a clear occur in the same cycle.

Reset
REQ-022 SHALL, on hreset=1 at an edge, clear wr_ptr, rd_ptr, ovf_err and rdata to 0; fifo_empty reads 1, fifo_full 0, opnd_valid 0.
REQ-023 SHALL leave storage contents unreset; they are unobservable while empty.
REQ-024 SHALL let reset mid-operation discard all entries with no pop reported afterwards.

Structure
REQ-025 SHALL place default CFG_ADDR/STS_ADDR offsets and the status bit positions in the shared multpool package.
REQ-026 SHALL implement storage as sub-module mul_fifo_ram (DEPTH x 2*DWIDTH, synchronous write, asynchronous read); pointers and control stay in the top.

Verification
REQ-027 SHALL cover: push {b=2,a=1} at CFG_ADDR, opnd_ready=0 -> next cycle opnd_valid=1, opnd_a=1, opnd_b=2, held until ready.
REQ-028 SHALL cover: 16 pushes -> fifo_full=1, status read = count 16, full=1; 17th push -> dropped, ovf_err=1.
REQ-029 SHALL cover: full FIFO with push and pop in the same cycle -> both accepted, count stays 16, ovf_err stays 0.
REQ-030 SHALL cover: 40 pushes/pops interleaved at random ready -> data order preserved across pointer wrap, no loss.
REQ-031 SHALL cover: write 3 to STS_ADDR with 5 entries and ovf_err=1 -> fifo_empty=1, ovf_err=0, status read = 0x1.
REQ-032 SHALL cover: hreset asserted with 7 entries -> opnd_valid=0, rdata=0, fifo_empty=1 next cycle.
